// File: rtl/fmul_iter.sv
// Iterative IEEE-754 single-precision multiplier: 24-cycle shift-add mantissa product, one normalise cycle.
// Optional round-to-nearest-even when FMUL_ITER_ROUND_EN is defined; truncation otherwise.
module fmul_iter (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s,
    input  logic [31:0] t,
    input  logic        valid_in,
    output logic        ready,
    output logic [31:0] d,
    output logic        overflow,
    output logic        underflow,
    output logic        valid_out,
    input  logic        out_ready
);
    // state | meaning
    // IDLE  | waiting for operands, ready=1
    // MUL   | 24 shift-add steps, one multiplier bit per cycle, LSB first
    // NORM  | normalise, round, range-check; register result
    // DONE  | result held with valid_out=1 until out_ready
    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [47:0] mcand;
    logic [23:0] mplier;
    logic [47:0] prod;
    logic        sign_r;
    logic [7:0]  es;
    logic [7:0]  et;

    logic              carry;
    logic [22:0]       mant_t;
    logic              round_up;
    logic [23:0]       mant_r;
    logic signed [9:0] e_n;
    logic [31:0]       d_n;
    logic              ovf_n;
    logic              unf_n;

`ifdef FMUL_ITER_ROUND_EN
    logic g_bit;
    logic r_bit;
    logic sticky;
`else
    logic unused_lo;
    assign unused_lo = ^prod[22:0];
`endif

    always_comb begin
        carry  = prod[47];
        mant_t = carry ? prod[46:24] : prod[45:23];
`ifdef FMUL_ITER_ROUND_EN
        if (carry) begin
            g_bit  = prod[23];
            r_bit  = prod[22];
            sticky = |prod[21:0];
        end else begin
            g_bit  = prod[22];
            r_bit  = prod[21];
            sticky = |prod[20:0];
        end
        round_up = g_bit & (r_bit | sticky | mant_t[0]);
`else
        round_up = 1'b0;
`endif
        // a carry out of the rounded mantissa leaves [22:0] at zero and bumps the exponent
        mant_r = {1'b0, mant_t} + {23'b0, round_up};
        e_n    = {2'b00, es} + {2'b00, et} - 10'd127 + {9'b0, carry} + {9'b0, mant_r[23]};

        d_n   = {sign_r, e_n[7:0], mant_r[22:0]};
        ovf_n = 1'b0;
        unf_n = 1'b0;
        if (es == 8'd0 || et == 8'd0) begin
            d_n = {sign_r, 31'b0};
        end else if (e_n >= 10'sd255) begin
            d_n   = {sign_r, 8'hFF, 23'b0};
            ovf_n = 1'b1;
        end else if (e_n <= 10'sd0) begin
            d_n   = {sign_r, 31'b0};
            unf_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ready     <= 1'b1;
            valid_out <= 1'b0;
            d         <= 32'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            cnt       <= 5'd0;
            prod      <= 48'b0;
            mcand     <= 48'b0;
            mplier    <= 24'b0;
            sign_r    <= 1'b0;
            es        <= 8'd0;
            et        <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        sign_r <= s[31] ^ t[31];
                        es     <= s[30:23];
                        et     <= t[30:23];
                        mcand  <= {24'b0, 1'b1, s[22:0]};
                        mplier <= {1'b1, t[22:0]};
                        prod   <= 48'b0;
                        cnt    <= 5'd0;
                        ready  <= 1'b0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd23) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    d         <= d_n;
                    overflow  <= ovf_n;
                    underflow <= unf_n;
                    valid_out <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        valid_out <= 1'b0;
                        ready     <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
